if_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU: holds the program counter, addresses instruction memory, and registers the fetched word into the IF/ID pipeline register. The IF/ID instruction output drives the decode stage and the opcode-to-type debug decoder. Stall comes from the hazard unit and flush/redirect from the branch/jump resolution logic.

---
 rtl/if_stage_pkg.sv | 30 +++
 rtl/if_stage_if_id_reg.sv | 32 +++
 rtl/if_stage.sv | 82 ++++++++
 tb/tb_if_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch-stage constants, opcode encodings and helpers
package if_stage_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_IMEM_AW  = 8;

    typedef enum logic [1:0] {
        PC_ADVANCE,
        PC_HOLD,
        PC_REDIRECT
    } pc_sel_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register with flush-over-stall priority
import if_stage_pkg::*;

module if_id_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= NOP;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (!stall) begin
            instr <= next_instr;
            pc4   <= next_pc4;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage; optional perf counters under IF_PERF_CNT_EN
import if_stage_pkg::*;

module if_stage #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = DEFAULT_IMEM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        bubble_cnt,
`endif
    output logic [31:0]        pc,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid
);

    pc_sel_e     pc_sel;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[IMEM_AW+1:2];

    always_comb begin
        pc_sel = PC_ADVANCE;
        if (flush)
            pc_sel = PC_REDIRECT;
        else if (stall)
            pc_sel = PC_HOLD;
    end

    always_comb begin
        pc_next = pc_plus4;
        case (pc_sel)
            PC_REDIRECT: pc_next = word_align(redirect_pc);
            PC_HOLD:     pc_next = pc;
            default:     pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= word_align(RESET_PC);
        else
            pc <= pc_next;
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .next_instr (imem_data),
        .next_pc4   (pc_plus4),
        .instr      (if_id_instr),
        .pc4        (if_id_pc4),
        .valid      (if_id_valid)
    );

`ifdef IF_PERF_CNT_EN
    // A flush edge counts as a bubble even if stall is also high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt  <= 32'h0;
            bubble_cnt <= 32'h0;
        end else if (pc_sel == PC_REDIRECT) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end else if (pc_sel == PC_ADVANCE) begin
            fetch_cnt  <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage (honours IF_PERF_CNT_EN)
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [7:0]  imem_addr, w_imem_addr;
    logic [31:0] imem_data, w_imem_data;
    logic [31:0] pc, if_id_instr, if_id_pc4;
    logic        if_id_valid;
    logic [31:0] w_pc, w_instr, w_pc4;
    logic        w_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt, w_fetch_cnt, w_bubble_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instruction memory: word k holds k+1.
    assign imem_data   = 32'(imem_addr) + 32'd1;
    assign w_imem_data = 32'(w_imem_addr) + 32'd1;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt   (fetch_cnt),
        .bubble_cnt  (bubble_cnt),
`endif
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_addr   (w_imem_addr),
        .imem_data   (w_imem_data),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt   (w_fetch_cnt),
        .bubble_cnt  (w_bubble_cnt),
`endif
        .pc          (w_pc),
        .if_id_instr (w_instr),
        .if_id_pc4   (w_pc4),
        .if_id_valid (w_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the stage must hold after each edge.
    logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_bc;
    logic        m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fc = 0; m_bc = 0;
        end else if (flush) begin
            m_pc    = redirect_pc - (redirect_pc % 4);
            m_instr = 0;
            m_pc4   = 0;
            m_valid = 0;
            m_bc    = m_bc + 1;
        end else if (!stall) begin
            m_instr = (m_pc / 4) % 256 + 1;
            m_pc    = m_pc + 4;
            m_pc4   = m_pc;
            m_valid = 1;
            m_fc    = m_fc + 1;
        end
    end

    always @(negedge clk) begin
        if ($time > 1) begin
            check("pc", pc, m_pc);
            check("imem_addr", 32'(imem_addr), (m_pc / 4) % 256);
            check("if_id_instr", if_id_instr, m_instr);
            check("if_id_pc4", if_id_pc4, m_pc4);
            check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
`ifdef IF_PERF_CNT_EN
            check("fetch_cnt", fetch_cnt, m_fc);
            check("bubble_cnt", bubble_cnt, m_bc);
`endif
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_valid", 32'(if_id_valid), 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        rst = 1'b0;

        @(negedge clk);
        check("run1_instr", if_id_instr, 32'd1);
        check("run1_pc", pc, 32'd4);
        check("run1_valid", 32'(if_id_valid), 32'd1);
        check("wrap_pc", w_pc, 32'h0);
        check("wrap_pc4", w_pc4, 32'h0);
        check("wrap_instr", w_instr, 32'h100);
        @(negedge clk);
        check("run2_instr", if_id_instr, 32'd2);
        check("run2_pc", pc, 32'd8);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_pc", pc, 32'd8);
            check("stall_instr", if_id_instr, 32'd2);
        end
        stall = 1'b0;
        @(negedge clk);
        check("resume_instr", if_id_instr, 32'd3);
        check("resume_pc", pc, 32'd12);
`ifdef IF_PERF_CNT_EN
        check("stall_fetch_cnt", fetch_cnt, 32'd3);
`endif

        flush = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        flush = 1'b0;
        check("flush_valid", 32'(if_id_valid), 32'd0);
        check("flush_instr", if_id_instr, 32'd0);
        check("flush_pc", pc, 32'h40);
        @(negedge clk);
        check("target_instr", if_id_instr, 32'd17);
        check("target_pc4", if_id_pc4, 32'h44);
`ifdef IF_PERF_CNT_EN
        check("bubble_cnt1", bubble_cnt, 32'd1);
`endif

        flush = 1'b1; stall = 1'b1; redirect_pc = 32'h23;
        @(negedge clk);
        flush = 1'b0;
        check("fs_pc", pc, 32'h20);
        check("fs_valid", 32'(if_id_valid), 32'd0);
        @(negedge clk);
        check("fs_hold_pc", pc, 32'h20);

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_valid", 32'(if_id_valid), 32'd0);
        check("async_instr", if_id_instr, 32'd0);
        check("async_pc4", if_id_pc4, 32'd0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;

        flush = 1'b1; redirect_pc = 32'h3F8;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        check("edge_instr254", if_id_instr, 32'd255);
        @(negedge clk);
        check("edge_instr255", if_id_instr, 32'd256);
        @(negedge clk);
        check("edge_addr_wrap", if_id_instr, 32'd1);
        check("edge_pc", pc, 32'h404);

        for (int i = 0; i < 24; i++) begin
            stall       = (i % 5 == 2);
            flush       = (i % 7 == 3);
            redirect_pc = 32'h100 + 32'(i) * 12 + 32'(i % 4);
            @(negedge clk);
        end
        stall = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
